// File: rtl/pipelined_cla_adder_if.sv
// Operand/result bundle for pipelined_cla_adder: valid/ready operand channel in, valid/ready result channel out.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovfl;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovfl, zero, neg
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovfl, zero, neg
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined WIDTH-bit carry-lookahead add/subtract: one 4-bit slice per stage, valid/ready with full-pipeline stall.
// Optional macro PIPE_SAT_EN: on signed overflow the delivered sum saturates toward the sign of A.
module pipelined_cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    pipelined_cla_adder_if.slave bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int NPIPE  = (NSLICE > 1) ? NSLICE - 1 : 1;
    localparam int MSB    = WIDTH - 1;

    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_width_check
        $error("pipelined_cla_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = x ^ y;
        g    = x & y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

`ifdef PIPE_SAT_EN
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] s, input logic a_msb,
                                                  input logic ov);
        if (!ov) return s;
        return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    logic              advance;
    logic [NSLICE-1:0] vld_d, vld_q;
    logic [NSLICE-1:0] c_d, c_q;
    logic [WIDTH-1:0]  s_d [NSLICE];
    logic [WIDTH-1:0]  s_q [NSLICE];
    logic [WIDTH-1:0]  a_d [NPIPE];
    logic [WIDTH-1:0]  a_q [NPIPE];
    logic [WIDTH-1:0]  b_d [NPIPE];
    logic [WIDTH-1:0]  b_q [NPIPE];
    logic              ovfl_d, ovfl_q;
    logic              zero_d, zero_q;
    logic              neg_d, neg_q;

    logic [WIDTH-1:0]  stg_a, stg_b, stg_s;
    logic              stg_c, stg_v;
    logic [4:0]        slice_r;

    // Stage k consumes slice k of the skewed operands; earlier sum bits ride along unchanged.
    always_comb begin
        advance = ~vld_q[NSLICE-1] | bus.out_ready;
        vld_d   = '0;
        c_d     = '0;
        ovfl_d  = 1'b0;
        zero_d  = 1'b0;
        neg_d   = 1'b0;
        stg_a   = '0;
        stg_b   = '0;
        stg_s   = '0;
        stg_c   = 1'b0;
        stg_v   = 1'b0;
        slice_r = '0;
        for (int k = 0; k < NSLICE; k++) s_d[k] = '0;
        for (int k = 0; k < NPIPE; k++) begin
            a_d[k] = '0;
            b_d[k] = '0;
        end
        for (int k = 0; k < NSLICE; k++) begin
            if (k == 0) begin
                stg_a = bus.a;
                stg_b = bus.sub ? ~bus.b : bus.b;
                stg_c = bus.sub | bus.cin;
                stg_s = '0;
                stg_v = bus.in_valid;
            end else begin
                stg_a = a_q[k-1];
                stg_b = b_q[k-1];
                stg_c = c_q[k-1];
                stg_s = s_q[k-1];
                stg_v = vld_q[k-1];
            end
            slice_r            = cla4(stg_a[4*k +: 4], stg_b[4*k +: 4], stg_c);
            stg_s[4*k +: 4]    = slice_r[3:0];
            vld_d[k]           = stg_v;
            c_d[k]             = slice_r[4];
            if (k < NSLICE - 1) begin
                a_d[k] = stg_a;
                b_d[k] = stg_b;
                s_d[k] = stg_s;
            end else begin
                ovfl_d = (stg_a[MSB] & stg_b[MSB] & ~stg_s[MSB])
                       | (~stg_a[MSB] & ~stg_b[MSB] & stg_s[MSB]);
`ifdef PIPE_SAT_EN
                stg_s  = saturate(stg_s, stg_a[MSB], ovfl_d);
`endif
                s_d[k] = stg_s;
                zero_d = (stg_s == '0);
                neg_d  = stg_s[MSB];
            end
        end
    end

    // Output stage only reloads on a real result, so a bubble leaves the last delivered values in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q         <= '0;
            c_q[NSLICE-1] <= 1'b0;
            s_q[NSLICE-1] <= '0;
            ovfl_q        <= 1'b0;
            zero_q        <= 1'b0;
            neg_q         <= 1'b0;
        end else if (advance) begin
            vld_q <= vld_d;
            for (int k = 0; k < NSLICE - 1; k++) begin
                c_q[k] <= c_d[k];
                s_q[k] <= s_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
            end
            if (vld_d[NSLICE-1]) begin
                c_q[NSLICE-1] <= c_d[NSLICE-1];
                s_q[NSLICE-1] <= s_d[NSLICE-1];
                ovfl_q        <= ovfl_d;
                zero_q        <= zero_d;
                neg_q         <= neg_d;
            end
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = vld_q[NSLICE-1];
    assign bus.sum       = s_q[NSLICE-1];
    assign bus.cout      = c_q[NSLICE-1];
    assign bus.ovfl      = ovfl_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined successor to the 4-bit CLA slice for the datapath ALU.
- Splits a WIDTH-bit add/subtract into WIDTH/4 carry-lookahead slices, one slice per pipeline stage. The carry is registered between stages.
- Uses a valid/ready handshake with full-pipeline stall. Produces sum plus carry, signed-overflow, zero and negative flags.
- Throughput is one operation per cycle; latency is WIDTH/4 cycles.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and >= 4; any other value is an elaboration error.
- NSLICE, WIDTH/4, derived localparam. Number of 4-bit slices, which equals the number of pipeline stages.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand presented
- in_ready  out  1  block accepts operand this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  1: A-B; 0: A+B+cin
- cin  in  1  carry-in for add; ignored when sub=1
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (for subtract, 1 = no borrow)
- ovfl  out  1  signed two's-complement overflow
- zero  out  1  sum == 0
- neg  out  1  sum[WIDTH-1]

Behaviour:
- Arithmetic:
  - Effective B is ~b when sub=1, else b.
  - Effective carry-in is 1 when sub=1, else cin.
  - Within each slice: p=a^b, g=a&b, and lookahead carries c(i+1) = g(i) | p(i)&c(i).
- Pipelining:
  - Stage k computes slice bits [4k+3:4k] from the carry registered by stage k-1.
  - Not-yet-consumed upper operand bits and already-computed lower sum bits are carried forward in stage registers (skew/deskew).
  - Results emerge in order.
- Flags, all computed at the final stage:
  - ovfl = (A[MSB]&Beff[MSB]&~S[MSB]) | (~A[MSB]&~Beff[MSB]&S[MSB]), using the pre-saturation sum.
  - cout is the MSB slice carry-out.
  - zero and neg are computed on the delivered sum.
- Handshake:
  - advance = ~out_valid | out_ready; in_ready = advance.
  - An operand is accepted when in_valid & in_ready.
  - When advance=0 every stage register, including the output, holds; outputs stay stable.
  - in_valid while in_ready=0 is not accepted and not latched.
  - Bubbles propagate as per-stage valid bits. A stage with valid=0 does not update out_valid beyond passing the bubble.
- Latency: an operand accepted in cycle t appears with out_valid=1 in cycle t+NSLICE, provided no stall occurs.
- Result is consumed when out_valid & out_ready. Each accepted operand yields exactly one result, with no drop and no duplicate.
- Reset:
  - All stage valid bits clear, out_valid=0, sum=0, cout=0, ovfl=0, zero=0, neg=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight operations; no stale result is ever presented.
- Simultaneous events:
  - Accept and deliver in the same cycle is legal and required for full throughput.
  - rst dominates in_valid and out_ready.
- Wrap-around: unsigned overflow wraps modulo 2^WIDTH, with cout=1 (without PIPE_SAT_EN).
- WIDTH=4: single stage, latency 1.

Optional Feature:
- Macro PIPE_SAT_EN.
- Defined: on ovfl=1, sum saturates to 0111..1 if A[MSB]=0, else 1000..0. ovfl still reads 1; zero and neg reflect the saturated value; cout is unchanged.
- Undefined: sum is the wrapped result; no saturation logic is present.

Test Plan:
- Overflow: WIDTH=16, a=0x7FFF, b=0x0001, sub=0, cin=0 -> after 4 cycles sum=0x8000, ovfl=1, neg=1, cout=0, zero=0.
- Subtract to zero: a=0x0005, b=0x0005, sub=1 -> sum=0x0000, zero=1, cout=1, ovfl=0.
- Cross-slice carry and throughput: back-to-back operations 0x00FF+0x0001, 0x0FFF+0x0001, 0xFFFF+0x0001 (cin=0) on consecutive cycles -> results 0x0100, 0x1000, 0x0000 (last with cout=1, zero=1) on consecutive cycles, in order.
- Backpressure: pipeline full, out_ready=0 for 3 cycles -> in_ready=0 and sum/flags stable throughout; after release all results are delivered once, in order.
- Reset mid-operation: 3 operations in flight, rst pulsed 1 cycle -> out_valid=0 after reset and no result from those operations ever appears; a new operation 0x0002+0x0003 yields 0x0005 after 4 cycles.
- PIPE_SAT_EN: 0x7FFF+0x0001 -> 0x7FFF, ovfl=1; 0x8000-0x0001 -> 0x8000, ovfl=1, neg=1.
